// File: rtl/scan_data_path.sv
// scan_data_path: bit-scan datapath with its own start/busy/done sequencer.
//
// An accepted start loads x into y. The scan index s then walks across y with
// a fixed stride, ascending from 0 or descending from W-1. On every visited
// bit that is 1, y is updated by the selected operation.
//
// Parameters
//   W   data width of x/y (>= 2)
//   SW  width of bit index s and of step
//
// Ports
//   clk    clock; all state changes on posedge
//   rst    synchronous reset, active-high; aborts any scan in progress
//   start  command strobe; accepted only in IDLE
//   x      operand, loaded into y when start is accepted
//   op     update applied on a 1-bit: 0 hold, 1 y+1, 2 y+s, 3 y-s
//   step   index stride; a stride of 0 is treated as 1
//   dir    0: s ascends from 0; 1: s descends from W-1
//   busy   high in every scan cycle
//   done   one-cycle pulse after the last scan cycle
//   y      data register
//   s      current bit index
//   b      y[s], combinational
//   hits   (SCAN_COUNT_EN only) number of scan cycles with b=1 in the current scan
//
// Build option: define SCAN_COUNT_EN to add the hits counter and port.
module scan_data_path #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x,
  input  logic [1:0]    op,
  input  logic [SW-1:0] step,
  input  logic          dir,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  y,
  output logic [SW-1:0] s,
  output logic          b
`ifdef SCAN_COUNT_EN
  ,
  output logic [SW:0]   hits
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state;
  logic [1:0]    op_r;
  logic [SW-1:0] step_r;
  logic          dir_r;

  logic [W-1:0]  s_ext;
  logic [W-1:0]  y_upd;
  logic [SW:0]   s_up;
  logic          last;

  assign b = y[s];

  always_comb begin
    s_ext = W'(s);
    y_upd = y;
    case (op_r)
      2'd0: y_upd = y;
      2'd1: y_upd = y + W'(1);
      2'd2: y_upd = y + s_ext;
      2'd3: y_upd = y - s_ext;
      default: y_upd = y;
    endcase
    // The next index is formed one bit wider, so the end of the scan is detected
    // before s could wrap.
    s_up = {1'b0, s} + {1'b0, step_r};
    if (dir_r)
      last = (s < step_r);
    else
      last = (s_up > (SW+1)'(W-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      y      <= '0;
      s      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      op_r   <= '0;
      step_r <= SW'(1);
      dir_r  <= 1'b0;
`ifdef SCAN_COUNT_EN
      hits   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            y      <= x;
            s      <= dir ? SW'(W-1) : '0;
            op_r   <= op;
            step_r <= (step == '0) ? SW'(1) : step;
            dir_r  <= dir;
            busy   <= 1'b1;
            state  <= SCAN;
`ifdef SCAN_COUNT_EN
            hits   <= '0;
`endif
          end
        end
        SCAN: begin
          if (b) begin
            y <= y_upd;
`ifdef SCAN_COUNT_EN
            hits <= hits + (SW+1)'(1);
`endif
          end
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            s <= dir_r ? (s - step_r) : s_up[SW-1:0];
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_data_path.sv
module tb_scan_data_path;

  localparam int W  = 8;
  localparam int SW = 3;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst, start, dir;
  logic [W-1:0]  x;
  logic [1:0]    op;
  logic [SW-1:0] step;
  logic          busy, done, b;
  logic [W-1:0]  y;
  logic [SW-1:0] s;
`ifdef SCAN_COUNT_EN
  logic [SW:0]   hits;
`endif

  int n_total = 0;
  int n_pass  = 0;

  scan_data_path #(.W(W), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .op(op), .step(step), .dir(dir),
    .busy(busy), .done(done), .y(y), .s(s), .b(b)
`ifdef SCAN_COUNT_EN
    , .hits(hits)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".y"}, int'(y), 0);
    check({tag, ".s"}, int'(s), 0);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".done"}, int'(done), 0);
    check({tag, ".b"}, int'(b), 0);
`ifdef SCAN_COUNT_EN
    check({tag, ".hits"}, int'(hits), 0);
`endif
  endtask

  // Model: the visited indices are k*stride from one end of y; each visited
  // 1-bit applies op with modular arithmetic. abort_at>0 resets in that scan cycle.
  task automatic run_scan(input int vx, input int vop, input int vstep, input int vdir,
                          input bit junk, input int abort_at);
    int st, n, yv, hv, sv;
    int exp_s[W+1];
    int exp_y[W+2];
    int exp_h[W+2];
    st = (vstep == 0) ? 1 : vstep;
    n  = (W - 1) / st + 1;
    yv = vx; hv = 0;
    for (int k = 0; k < n; k++) begin
      sv = vdir ? (W - 1 - k * st) : (k * st);
      exp_s[k] = sv; exp_y[k] = yv; exp_h[k] = hv;
      if (((yv >> sv) & 1) == 1) begin
        hv++;
        case (vop)
          1: yv = (yv + 1) & MASK;
          2: yv = (yv + sv) & MASK;
          3: yv = (yv - sv) & MASK;
          default: yv = yv;
        endcase
      end
    end
    exp_y[n] = yv; exp_h[n] = hv;

    @(negedge clk);
    x = W'(vx); op = 2'(vop); step = SW'(vstep); dir = vdir[0]; start = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("scan.busy", int'(busy), 1);
      check("scan.done", int'(done), 0);
      check("scan.s", int'(s), exp_s[k-1]);
      check("scan.y", int'(y), exp_y[k-1]);
      check("scan.b", int'(b), (exp_y[k-1] >> exp_s[k-1]) & 1);
`ifdef SCAN_COUNT_EN
      check("scan.hits", int'(hits), exp_h[k-1]);
`endif
      if (junk) begin
        start = 1'($urandom); x = W'($urandom); op = 2'($urandom);
        step = SW'($urandom); dir = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      if (k == abort_at) begin
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        check_reset_state("abort");
        rst = 1'b0;
        for (int j = 0; j < n + 2; j++) begin
          @(negedge clk);
          check("abort.nodone", int'(done), 0);
          check("abort.nobusy", int'(busy), 0);
        end
        return;
      end
    end
    @(negedge clk);
    check("done.pulse", int'(done), 1);
    check("done.busy", int'(busy), 0);
    check("done.y", int'(y), exp_y[n]);
    check("done.s", int'(s), exp_s[n-1]);
`ifdef SCAN_COUNT_EN
    check("done.hits", int'(hits), exp_h[n]);
`endif
    if (junk) start = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("idle.done", int'(done), 0);
    check("idle.busy", int'(busy), 0);
    check("idle.y", int'(y), exp_y[n]);
    check("idle.s", int'(s), exp_s[n-1]);
`ifdef SCAN_COUNT_EN
    check("idle.hits", int'(hits), exp_h[n]);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; op = '0; step = '0; dir = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    run_scan(8'hA5, 1, 1, 0, 1'b0, 0);
    run_scan(8'hFF, 2, 2, 0, 1'b0, 0);
    run_scan(8'h80, 3, 3, 1, 1'b0, 0);
    run_scan(8'hA5, 1, 1, 0, 1'b0, 3);
    run_scan(8'hA5, 1, 1, 0, 1'b0, 0);
    run_scan(8'h01, 1, 0, 0, 1'b1, 0);
    run_scan(8'h00, 1, 1, 0, 1'b0, 0);
    run_scan(8'h5A, 0, 1, 0, 1'b0, 0);
    run_scan(8'hFF, 3, 7, 1, 1'b0, 0);
    run_scan(8'hFF, 2, 7, 0, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      run_scan(int'($urandom_range(MASK, 0)), int'($urandom_range(3, 0)),
               int'($urandom_range(7, 0)), int'($urandom_range(1, 0)),
               1'($urandom), (i % 10 == 9) ? int'($urandom_range(2, 1)) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
